// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// Purpose : sequence PLL rst and core reset from the PLL lock indication, re-sequencing on lock loss.
// Latency : locked -> locked_s 2 cycles; outputs registered from next-state (same edge as state).
// Backpressure: none; no handshake, sw_reset is accepted every cycle and overrides all transitions.
//
// Ports:
//   clk          50 MHz reference clock (PLL refclk net)
//   rst_n        asynchronous active-low reset
//   locked       PLL lock, asynchronous to clk (synchronized internally)
//   sw_reset     one-cycle synchronous re-sequence request
//   pll_rst      active-high reset to the PLL
//   core_reset   synchronous active-high reset to the core
//   ready        high only in RUN
//   lock_lost    one-cycle pulse on lock loss while in RUN
//   retry_count  saturating count of WAIT timeouts (0 when retry is not compiled in)
//   state        0 PLLRST, 1 WAIT, 2 STABLE, 3 RUN
//
// Build option: define PLL_SUP_RETRY_EN to enable the WAIT timeout / retry path.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count,
    output logic [1:0] state
);

    localparam logic [1:0] ST_PLLRST = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STABLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Elaboration-time sanity check: every terminal count must fit the shared counter.
    if (PLL_RST_CYCLES < 2 || STABLE_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        64'(PLL_RST_CYCLES) > (64'd1 << CNT_W) ||
        64'(STABLE_CYCLES)  > (64'd1 << CNT_W) ||
        64'(LOCK_TIMEOUT)   > (64'd1 << CNT_W)) begin : g_bad_params
        $error("pll_lock_supervisor: invalid parameter set");
    end

    logic             sync_ff;
    logic             locked_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifdef PLL_SUP_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic       retry_inc;
    logic [7:0] retry_q;
`endif

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff  <= locked;
            locked_s <= sync_ff;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
`ifdef PLL_SUP_RETRY_EN
        retry_inc = 1'b0;
`endif
        if (sw_reset) begin
            state_d = ST_PLLRST;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end
`ifdef PLL_SUP_RETRY_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = ST_PLLRST;
                        retry_inc = 1'b1;
                    end
`endif
                end
                ST_STABLE: begin
                    // A single low sample sends us back to WAIT; this is glitch
                    // rejection, not a retry.
                    if (!locked_s)                 state_d = ST_WAIT;
                    else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
                end
                default: begin
                    cnt_d = cnt_q;  // counter is idle in RUN
                    if (!locked_s) state_d = ST_PLLRST;
                end
            endcase
        end
        // Counter restarts on every state entry, and on sw_reset while already in PLLRST.
        if (sw_reset || (state_d != state_q)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PLLRST;
            cnt_q      <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst    <= (state_d == ST_PLLRST);
            core_reset <= (state_d != ST_RUN);
            ready      <= (state_d == ST_RUN);
            // sw_reset wins over lock loss, so the pulse is suppressed when both coincide.
            lock_lost  <= (state_q == ST_RUN) && !locked_s && !sw_reset;
        end
    end

`ifdef PLL_SUP_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 8'd0;
        end else if (retry_inc && (retry_q != 8'hFF)) begin
            retry_q <= retry_q + 8'd1;
        end
    end
    assign retry_count = retry_q;
`else
    assign retry_count = 8'd0;
`endif

    assign state = state_q;

endmodule
